// File: rtl/hbc_arb_pkg.sv
// Shared definitions for the HyperBus controller port arbiter.
//   arb_state_t : arbiter FSM states
//   GNT_CPU/DMA : requester ids used for grant, owner and round-robin state
//   ADDR_MASK   : hbc only decodes a 24-bit byte address; upper bits are dropped
package hbc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  localparam logic [23:0] ADDR_MASK = 24'hFF_FFFF;

endpackage

// File: rtl/hbc_arbiter.sv
// Two-port arbiter sharing the single hbc memory/config port between the CPU
// iomem bus (requester 0) and a read-only display/DMA fetch engine (requester 1).
//
// Ports:
//   clk, resetn             clock and synchronous active-low reset
//   r0_valid/cfg/wstrb/addr/wdata -> r0_ready/r0_rdata   CPU request/response
//   r1_valid/addr           -> r1_ready/r1_rdata         DMA read request/response
//   m_cfg_access/valid/wstrb/addr/wdata <- m_ready/m_rdata   hbc port
//   timeout_err             sticky watchdog abort flag
//   dbg_state               current FSM state (arb_state_t encoding)
//
// Handshake: a requester raises rN_valid with stable request fields and holds
// it until a one-cycle rN_ready pulse; rN_rdata is valid while rN_ready is
// high and holds its value afterwards. Towards hbc, m_valid and the latched
// fields stay constant until hbc returns a single-cycle m_ready (or the
// watchdog aborts). m_ready outside BUSY is ignored.
module hbc_arbiter
  import hbc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        r0_valid,
  input  logic        r0_cfg,
  input  logic [3:0]  r0_wstrb,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ready,
  output logic [31:0] r0_rdata,
  input  logic        r1_valid,
  input  logic [31:0] r1_addr,
  output logic        r1_ready,
  output logic [31:0] r1_rdata,
  output logic        m_cfg_access,
  output logic        m_valid,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic        WD_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [31:0] ADDR_KEEP = {8'h00, ADDR_MASK};

  arb_state_t    state, state_nxt;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] wd_cnt;

  logic          grant;
  logic          pick;
  logic          finish;
  logic          abort;
  logic [31:0]   rsp_data;

  assign dbg_state = state;
  assign rsp_data  = finish ? m_rdata : ERR_DATA;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick      = GNT_CPU;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester that did not win last time goes next.
        if (r0_valid && r1_valid) begin
          grant = 1'b1;
          pick  = ~last_grant;
        end else if (r0_valid) begin
          grant = 1'b1;
          pick  = GNT_CPU;
        end else if (r1_valid) begin
          grant = 1'b1;
          pick  = GNT_DMA;
        end
        if (grant) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A reply arriving on the threshold cycle beats the watchdog.
        if (m_ready) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Dead cycle so the owner can drop valid before the next pick.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant   <= GNT_DMA;
      owner        <= GNT_CPU;
      wd_cnt       <= '0;
      m_valid      <= 1'b0;
      m_cfg_access <= 1'b0;
      m_wstrb      <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
      r0_ready     <= 1'b0;
      r0_rdata     <= '0;
      r1_ready     <= 1'b0;
      r1_rdata     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      r0_ready <= 1'b0;
      r1_ready <= 1'b0;

      if (grant) begin
        m_valid    <= 1'b1;
        owner      <= pick;
        last_grant <= pick;
        wd_cnt     <= '0;
        if (pick == GNT_CPU) begin
          m_cfg_access <= r0_cfg;
          m_wstrb      <= r0_wstrb;
          m_addr       <= r0_addr & ADDR_KEEP;
          m_wdata      <= r0_wdata;
        end else begin
          // DMA is a pure memory reader.
          m_cfg_access <= 1'b0;
          m_wstrb      <= '0;
          m_addr       <= r1_addr & ADDR_KEEP;
          m_wdata      <= '0;
        end
      end

      if (finish || abort) begin
        m_valid <= 1'b0;
        if (owner == GNT_CPU) begin
          r0_ready <= 1'b1;
          r0_rdata <= rsp_data;
        end else begin
          r1_ready <= 1'b1;
          r1_rdata <= rsp_data;
        end
        if (abort) begin
          timeout_err <= 1'b1;
        end
      end else if ((state == BUSY) && WD_EN) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hbc_arbiter.sv
// Self-checking bench for hbc_arbiter: table of single/contending requests,
// plus hand sequences for alternation, watchdog, race, stray m_ready and
// reset in the middle of a transaction.
module tb_hbc_arbiter;
  import hbc_arb_pkg::*;

  logic        clk;
  logic        resetn;
  logic        r0_valid, r0_cfg;
  logic [3:0]  r0_wstrb;
  logic [31:0] r0_addr, r0_wdata;
  logic        r0_ready;
  logic [31:0] r0_rdata;
  logic        r1_valid;
  logic [31:0] r1_addr;
  logic        r1_ready;
  logic [31:0] r1_rdata;
  logic        m_cfg_access, m_valid;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  hbc_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_cfg(r0_cfg), .r0_wstrb(r0_wstrb),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .m_cfg_access(m_cfg_access), .m_valid(m_valid), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];   // {port, rdata}

  // requester models
  int          r0_total, r0_done, r1_total, r1_done;
  logic [31:0] r0_base, r1_base;
  // hbc model
  int          hbc_delay;        // 0: never reply
  logic [31:0] hbc_data;
  logic        hbc_use_mem;
  int          hcnt;
  // monitors
  int          mv_len, last_mv_len, gap;
  logic        mv_prev, r0_prev, r1_prev, gap_valid, chk_gap;
  // first-grant field check
  logic        chk_on, exp_first, exp_cfg;
  logic [31:0] exp_maddr, exp_wdata;
  logic [3:0]  exp_wstrb;

  typedef struct {
    logic        r0_v;
    logic        r0_cfg;
    logic [3:0]  r0_wstrb;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r1_v;
    logic [31:0] r1_addr;
    int          delay;
    logic [31:0] hdata;
    logic        exp_first;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wstrb;
    logic        exp_cfg;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic port, input logic [31:0] rdata);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ready: port %0d rdata 0x%08h with no expectation at %0t",
               port, rdata, $time);
    end else begin
      e = exp_q.pop_front();
      check("ready_port", 32'(port), 32'(e[32]));
      check("rdata", rdata, e[31:0]);
    end
  endtask

  // One clock of the whole environment, evaluated on the falling edge.
  task automatic env_cycle();
    @(negedge clk);
    // scoreboard
    if (r0_ready) sb_pop(GNT_CPU, r0_rdata);
    if (r1_ready) sb_pop(GNT_DMA, r1_rdata);
    if (r0_prev) check("r0_ready_pulse", 32'(r0_ready), 32'd0);
    if (r1_prev) check("r1_ready_pulse", 32'(r1_ready), 32'd0);
    r0_prev = r0_ready;
    r1_prev = r1_ready;
    // response-to-next-grant spacing
    if (r0_ready || r1_ready) begin
      gap = 0;
      gap_valid = 1'b1;
    end else begin
      gap++;
    end
    if (m_valid && !mv_prev && chk_gap && gap_valid) check("regrant_gap", 32'(gap), 32'd2);
    if (m_valid) mv_len++;
    else if (mv_len != 0) begin
      last_mv_len = mv_len;
      mv_len = 0;
    end
    mv_prev = m_valid;
    // latched fields of the first grant; then disturb the requester inputs
    if (m_valid && chk_on) begin
      check("m_addr", m_addr, exp_maddr);
      check("m_wstrb", 32'(m_wstrb), 32'(exp_wstrb));
      check("m_cfg_access", 32'(m_cfg_access), 32'(exp_cfg));
      if (exp_first == GNT_CPU) begin
        check("m_wdata", m_wdata, exp_wdata);
        r0_addr  = ~r0_addr;
        r0_wdata = ~r0_wdata;
        r0_wstrb = ~r0_wstrb;
        r0_cfg   = ~r0_cfg;
      end else begin
        r1_addr = ~r1_addr;
      end
    end
    // hbc model
    if (m_ready) begin
      m_ready = 1'b0;
      m_rdata = $urandom();
      hcnt = 0;
      if (hbc_use_mem) hbc_delay = $urandom_range(1, 4);
    end else if (m_valid) begin
      hcnt++;
      if (hbc_delay != 0 && hcnt == hbc_delay) begin
        m_ready = 1'b1;
        m_rdata = hbc_use_mem ? mem_f(m_addr) : hbc_data;
      end
    end else begin
      hcnt = 0;
    end
    // requester models
    if (r0_ready) begin
      r0_done++;
      if (chk_on && exp_first == GNT_CPU) chk_on = 1'b0;
      if (r0_done < r0_total) r0_addr = r0_base + 32'(4 * r0_done);
      else r0_valid = 1'b0;
    end
    if (r1_ready) begin
      r1_done++;
      if (chk_on && exp_first == GNT_DMA) chk_on = 1'b0;
      if (r1_done < r1_total) r1_addr = r1_base + 32'(4 * r1_done);
      else r1_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    int t = 0;
    while ((r0_done < r0_total || r1_done < r1_total) && t < limit) begin
      env_cycle();
      t++;
    end
    check(name, 32'(t < limit), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; m_ready = 1'b0;
    r0_total = 0; r0_done = 0; r1_total = 0; r1_done = 0;
    chk_on = 1'b0; chk_gap = 1'b0; gap_valid = 1'b0;
    hcnt = 0; mv_len = 0; mv_prev = 1'b0; r0_prev = 1'b0; r1_prev = 1'b0;
    @(negedge clk);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_cfg"}, 32'(m_cfg_access), 32'd0);
    check({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
    check({tag, "_r0_ready"}, 32'(r0_ready), 32'd0);
    check({tag, "_r0_rdata"}, r0_rdata, 32'd0);
    check({tag, "_r1_ready"}, 32'(r1_ready), 32'd0);
    check({tag, "_r1_rdata"}, r1_rdata, 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    resetn = 1'b1;
  endtask

  task automatic run_single(input logic port, input logic [31:0] addr, input int delay,
                            input logic [31:0] data);
    hbc_delay = delay;
    hbc_data = data;
    hbc_use_mem = 1'b0;
    chk_on = 1'b0;
    if (port == GNT_CPU) begin
      r0_total = 1; r0_done = 0; r0_base = addr; r0_addr = addr;
      r0_cfg = 1'b0; r0_wstrb = 4'h0; r0_wdata = 32'h0; r0_valid = 1'b1;
    end else begin
      r1_total = 1; r1_done = 0; r1_base = addr; r1_addr = addr; r1_valid = 1'b1;
    end
    exp_q.push_back({port, data});
    wait_done(200, "single_done");
  endtask

  initial begin
    vec_t v;
    int t;
    r0_cfg = 1'b0; r0_wstrb = 4'h0; r0_addr = '0; r0_wdata = '0; r1_addr = '0;
    m_rdata = '0; hbc_delay = 0; hbc_data = '0; hbc_use_mem = 1'b0;
    gap = 0; last_mv_len = 0;
    exp_first = 1'b0; exp_cfg = 1'b0; exp_maddr = '0; exp_wdata = '0; exp_wstrb = '0;

    //              r0_v cfg  wstrb addr           wdata          r1_v r1_addr        dly hdata          first    maddr          wstrb cfg  wdata
    vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_0000, 5, 32'h1234_5678, GNT_CPU, 32'h0000_0040, 4'h0, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0100_0200, 2, 32'h1111_1111, GNT_DMA, 32'h0000_0200, 4'h0, 1'b0, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 4'hF, 32'h0800_0002, 32'h0000_8F1F, 1'b0, 32'h0000_0000, 3, 32'hDEAD_0001, GNT_CPU, 32'h0000_0002, 4'hF, 1'b1, 32'h0000_8F1F};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFF12_3456, 1, 32'h0BAD_F00D, GNT_DMA, 32'h0012_3456, 4'h0, 1'b0, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b0, 4'h3, 32'hAB00_0010, 32'h0000_BEEF, 1'b1, 32'h0000_0020, 4, 32'h2222_3333, GNT_CPU, 32'h0000_0010, 4'h3, 1'b0, 32'h0000_BEEF};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b1, 32'h0000_0044, 3, 32'h4444_5555, GNT_CPU, 32'h0000_0040, 4'h0, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b0, 4'h8, 32'h0080_0000, 32'hA000_0000, 1'b0, 32'h0000_0000, 2, 32'h0F0F_0F0F, GNT_CPU, 32'h0080_0000, 4'h8, 1'b0, 32'hA000_0000};
    vecs[7] = '{1'b1, 1'b0, 4'h0, 32'h0000_000C, 32'h0000_0000, 1'b1, 32'h0200_0010, 6, 32'h6666_7777, GNT_DMA, 32'h0000_0010, 4'h0, 1'b0, 32'h0000_0000};

    do_reset("reset");

    // Contention straight after reset: CPU first, then strict alternation.
    hbc_use_mem = 1'b1;
    hbc_delay = 2;
    chk_gap = 1'b1;
    gap_valid = 1'b0;
    r0_base = 32'h0000_1000; r0_addr = r0_base; r0_total = 5; r0_done = 0;
    r1_base = 32'h0020_0000; r1_addr = r1_base; r1_total = 5; r1_done = 0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({GNT_CPU, mem_f(r0_base + 32'(4 * k))});
      exp_q.push_back({GNT_DMA, mem_f(r1_base + 32'(4 * k))});
    end
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    wait_done(500, "alternate_done");
    chk_gap = 1'b0;
    hbc_use_mem = 1'b0;
    repeat (2) env_cycle();

    // Table of single and contending requests.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      hbc_delay = v.delay;
      hbc_data = v.hdata;
      exp_first = v.exp_first;
      exp_maddr = v.exp_maddr;
      exp_wstrb = v.exp_wstrb;
      exp_cfg = v.exp_cfg;
      exp_wdata = v.exp_wdata;
      chk_on = 1'b1;
      r0_total = v.r0_v ? 1 : 0; r0_done = 0; r0_base = v.r0_addr; r0_addr = v.r0_addr;
      r0_cfg = v.r0_cfg; r0_wstrb = v.r0_wstrb; r0_wdata = v.r0_wdata;
      r1_total = v.r1_v ? 1 : 0; r1_done = 0; r1_base = v.r1_addr; r1_addr = v.r1_addr;
      if (v.r0_v && v.r1_v) begin
        exp_q.push_back({v.exp_first, v.hdata});
        exp_q.push_back({~v.exp_first, v.hdata});
      end else begin
        exp_q.push_back({v.r1_v, v.hdata});
      end
      r0_valid = v.r0_v;
      r1_valid = v.r1_v;
      wait_done(300, "vector_done");
      repeat (2) env_cycle();
    end
    check("no_err_after_table", 32'(timeout_err), 32'd0);

    // m_ready while idle must not disturb rdata or ready.
    m_rdata = 32'h5555_AAAA;
    m_ready = 1'b1;
    repeat (3) env_cycle();
    check("stray_r0_rdata", r0_rdata, 32'h6666_7777);
    check("stray_r1_rdata", r1_rdata, 32'h6666_7777);

    // Watchdog abort, then a good transaction with the flag still set.
    run_single(GNT_CPU, 32'h0000_0050, 0, 32'hFFFF_FFFF);
    check("wd_mvalid_len", 32'(last_mv_len), 32'd16);
    check("wd_err_set", 32'(timeout_err), 32'd1);
    repeat (2) env_cycle();
    run_single(GNT_DMA, 32'h0000_0054, 2, 32'h7777_0000);
    check("good_mvalid_len", 32'(last_mv_len), 32'd2);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    repeat (2) env_cycle();

    // Reply on the threshold cycle wins over the watchdog.
    do_reset("reset2");
    run_single(GNT_CPU, 32'h0000_0060, 16, 32'hCAFE_0016);
    check("race_mvalid_len", 32'(last_mv_len), 32'd16);
    check("race_no_err", 32'(timeout_err), 32'd0);
    repeat (2) env_cycle();

    // Reset while a DMA request is outstanding at hbc.
    hbc_delay = 0;
    r1_total = 1; r1_done = 0; r1_base = 32'h0000_0300; r1_addr = r1_base; r1_valid = 1'b1;
    t = 0;
    while (!m_valid && t < 20) begin
      env_cycle();
      t++;
    end
    check("midbusy_granted", 32'(m_valid), 32'd1);
    repeat (2) env_cycle();
    do_reset("midbusy");
    run_single(GNT_DMA, 32'h0000_0304, 4, 32'h3030_4040);
    check("after_reset_no_err", 32'(timeout_err), 32'd0);
    repeat (3) env_cycle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
